// File: rtl/ptw_arbiter_if.sv
// ptw_arbiter_if: bundles the walker-side and memory-side signals of the
// page-table-walk arbiter. The "master" modport is the arbiter's own view
// (it masters the shared memory read port); "slave" is the view of the
// walkers and the memory model connected around it.
interface ptw_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  // Walker side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ack;
  logic                          req_err;
  logic [DATA_WIDTH-1:0]         rsp_data;

  // Memory side
  logic                          mem_req;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_ack;

  // Status
  logic                          busy;
  logic [$clog2(NUM_REQ)-1:0]    grant_id;

  modport master (
    input  req_valid, req_addr, mem_rdata, mem_ack,
    output req_ack, req_err, rsp_data, mem_req, mem_addr, busy, grant_id
  );

  modport slave (
    output req_valid, req_addr, mem_rdata, mem_ack,
    input  req_ack, req_err, rsp_data, mem_req, mem_addr, busy, grant_id
  );
endinterface

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: round-robin arbiter sharing one page-table-walk memory read
// port between NUM_REQ MMU walkers. One access at a time: IDLE picks a
// walker, BUSY holds the memory request until mem_ack, RESP pulses the
// one-hot ack and gives the acked walker a cycle to drop its request.
// All outputs are registered.
//
// Optional feature: define PTW_ARB_TIMEOUT_EN to build a BUSY watchdog that
// abandons the access after TIMEOUT_CYCLES cycles and acks with req_err=1.
module ptw_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  ptw_arbiter_if.master     bus
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic                   mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
  logic                   busy_q, busy_d;

  // Arbitration result for the current cycle (only consumed in IDLE)
  logic                   found;
  logic [ID_W-1:0]        pick;
  logic [ADDR_WIDTH-1:0]  pick_addr;

`ifdef PTW_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_err_q, req_err_d;
`else
  // Without the watchdog the timeout length has no meaning; it is only
  // referenced here so the parameter list stays identical across builds.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
  end
`endif

  // Round-robin search: first requesting walker at or after the pointer,
  // wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    idx   = 0;
    found = 1'b0;
    pick  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    pick_addr = bus.req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequence
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    req_ack_d  = '0;
`ifdef PTW_ARB_TIMEOUT_EN
    req_err_d  = 1'b0;
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BUSY;
          grant_d    = pick;
          ptr_d      = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = pick_addr;
`ifdef PTW_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end

      BUSY: begin
        // Walker inputs are deliberately ignored here: the address was
        // captured at grant and a dropped request does not cancel the read.
        if (bus.mem_ack) begin
          state_d             = RESP;
          mem_req_d           = 1'b0;
          rsp_data_d          = bus.mem_rdata;
          req_ack_d[grant_q]  = 1'b1;
        end
`ifdef PTW_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Dropping mem_req cancels the access on the memory side.
          state_d             = RESP;
          mem_req_d           = 1'b0;
          rsp_data_d          = '0;
          req_ack_d[grant_q]  = 1'b1;
          req_err_d           = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      RESP: begin
        // Ack/err fall back to their zero defaults; no arbitration here so
        // the acked walker's request is gone before IDLE looks again.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, pointer and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
      req_ack_q  <= '0;
      busy_q     <= 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
      req_err_q  <= 1'b0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
      req_ack_q  <= req_ack_d;
      busy_q     <= busy_d;
`ifdef PTW_ARB_TIMEOUT_EN
      req_err_q  <= req_err_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.req_ack  = req_ack_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;
`ifdef PTW_ARB_TIMEOUT_EN
  assign bus.req_err  = req_err_q;
`else
  assign bus.req_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: self-checking bench for ptw_arbiter. Walkers and memory
// are driven from tasks; expectations come from a transaction-level model
// (round-robin pointer plus remembered addresses/data). Build with
// PTW_ARB_TIMEOUT_EN defined to exercise the watchdog path.
module tb_ptw_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NREQ = 3;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  ptw_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NREQ)) bus ();

  ptw_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.req_addr[i*AW +: AW] = a;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
  endtask

  // Reference round-robin choice: first requester at or after the pointer.
  function automatic int exp_grant(input logic [NREQ-1:0] v, input int p);
    for (int o = 0; o < NREQ; o++)
      if (v[(p + o) % NREQ]) return (p + o) % NREQ;
    return -1;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (bus.req_ack !== '0) begin bad++; $display("FAIL reset_req_ack: got %b want 0", bus.req_ack); end
    total++; if (bus.req_err !== 1'b0) begin bad++; $display("FAIL reset_req_err: got %b want 0", bus.req_err); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if ({bus.rsp_data, bus.mem_addr, bus.grant_id} !== '0) begin bad++;
      $display("FAIL reset_data_addr_id: got %h/%h/%0d want 0/0/0", bus.rsp_data, bus.mem_addr, bus.grant_id); end
  endtask

  task automatic test_single();
    do_reset();
    set_addr(0, 32'h8000_1004);
    bus.req_valid = 3'b001;
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin bad++;
      $display("FAIL single_mem_req: got req=%b busy=%b want 1/1", bus.mem_req, bus.busy); end
    total++; if (bus.mem_addr !== 32'h8000_1004) begin bad++;
      $display("FAIL single_mem_addr: got %h want 80001004", bus.mem_addr); end
    tick();
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2000_0C01;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    total++; if (bus.req_ack !== 3'b001 || bus.req_err !== 1'b0 || bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL single_ack: got ack=%b err=%b mem_req=%b want 001/0/0", bus.req_ack, bus.req_err, bus.mem_req); end
    total++; if (bus.rsp_data !== 32'h2000_0C01) begin bad++;
      $display("FAIL single_rsp_data: got %h want 20000c01", bus.rsp_data); end
    tick();
    total++; if (bus.req_ack !== '0 || bus.busy !== 1'b0 || bus.rsp_data !== 32'h2000_0C01) begin bad++;
      $display("FAIL single_after: got ack=%b busy=%b rsp=%h want 000/0/20000c01", bus.req_ack, bus.busy, bus.rsp_data); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_addr(0, 32'h0000_1000);
    set_addr(1, 32'h0000_2000);
    bus.req_valid = 3'b011;
    tick();
    total++; if (bus.grant_id !== 2'd0 || bus.mem_addr !== 32'h0000_1000) begin bad++;
      $display("FAIL simul_first: got id=%0d addr=%h want 0/00001000", bus.grant_id, bus.mem_addr); end
    // mem_ack in the very first BUSY cycle: minimum latency
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_0001;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = 3'b010;
    total++; if (bus.req_ack !== 3'b001) begin bad++;
      $display("FAIL simul_ack0: got %b want 001", bus.req_ack); end
    tick();
    total++; if (bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL simul_gap: got mem_req=%b want 0", bus.mem_req); end
    tick();
    total++; if (bus.mem_req !== 1'b1 || bus.grant_id !== 2'd1 || bus.mem_addr !== 32'h0000_2000) begin bad++;
      $display("FAIL simul_second: got req=%b id=%0d addr=%h want 1/1/00002000", bus.mem_req, bus.grant_id, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_contention();
    int g;
    int lat;
    logic [DW-1:0] d;
    do_reset();
    set_addr(0, 32'hA000_0000);
    set_addr(1, 32'hB000_0000);
    bus.req_valid = 3'b011;
    for (int k = 0; k < 6; k++) begin
      g = exp_grant(bus.req_valid, m_ptr);
      tick();
      total++; if (int'(bus.grant_id) != g || bus.mem_req !== 1'b1) begin bad++;
        $display("FAIL contention_grant[%0d]: got id=%0d req=%b want %0d/1", k, bus.grant_id, bus.mem_req, g); end
      m_ptr = (g + 1) % NREQ;
      lat = $urandom_range(1, 3);
      for (int c = 1; c < lat; c++) tick();
      d = $urandom;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = d;
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.req_ack !== (NREQ'(1) << g) || bus.rsp_data !== d) begin bad++;
        $display("FAIL contention_ack[%0d]: got ack=%b data=%h want %b/%h", k, bus.req_ack, bus.rsp_data, NREQ'(1) << g, d); end
      tick();
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_addr_hold();
    do_reset();
    set_addr(1, 32'hC0DE_0008);
    bus.req_valid = 3'b010;
    tick();
    for (int c = 0; c < 4; c++) begin
      set_addr(1, $urandom);
      tick();
      total++; if (bus.mem_addr !== 32'hC0DE_0008 || bus.mem_req !== 1'b1) begin bad++;
        $display("FAIL addr_hold[%0d]: got addr=%h req=%b want c0de0008/1", c, bus.mem_addr, bus.mem_req); end
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    total++; if (bus.req_ack !== 3'b010 || bus.rsp_data !== 32'h0BAD_F00D) begin bad++;
      $display("FAIL addr_hold_ack: got ack=%b data=%h want 010/0badf00d", bus.req_ack, bus.rsp_data); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    // Leave a non-zero response behind so the error response is observable.
    set_addr(2, 32'h0000_0300);
    bus.req_valid = 3'b100;
    tick();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    tick();
    set_addr(0, 32'h0000_0400);
    bus.req_valid = 3'b001;
    tick();
`ifdef PTW_ARB_TIMEOUT_EN
    for (int c = 1; c < TO; c++) begin
      tick();
      total++; if (bus.mem_req !== 1'b1 || bus.req_ack !== '0) begin bad++;
        $display("FAIL timeout_wait[%0d]: got req=%b ack=%b want 1/000", c, bus.mem_req, bus.req_ack); end
    end
    tick();
    bus.req_valid = '0;
    total++; if (bus.req_ack !== 3'b001 || bus.req_err !== 1'b1 || bus.rsp_data !== '0 || bus.mem_req !== 1'b0) begin bad++;
      $display("FAIL timeout_expire: got ack=%b err=%b rsp=%h req=%b want 001/1/0/0",
               bus.req_ack, bus.req_err, bus.rsp_data, bus.mem_req); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.req_ack !== '0 || bus.mem_req !== 1'b0 || bus.rsp_data !== '0) begin bad++;
        $display("FAIL timeout_late_ack[%0d]: got ack=%b req=%b rsp=%h want 000/0/0", c, bus.req_ack, bus.mem_req, bus.rsp_data); end
    end
    bus.mem_ack = 1'b0;
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (bus.mem_req !== 1'b1 || bus.req_ack !== '0) begin bad++;
        $display("FAIL no_timeout_wait[%0d]: got req=%b ack=%b want 1/000", c, bus.mem_req, bus.req_ack); end
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    total++; if (bus.req_ack !== 3'b001 || bus.req_err !== 1'b0 || bus.rsp_data !== 32'h5555_AAAA) begin bad++;
      $display("FAIL no_timeout_ack: got ack=%b err=%b rsp=%h want 001/0/5555aaaa", bus.req_ack, bus.req_err, bus.rsp_data); end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_addr(0, 32'h0000_0500);
    set_addr(1, 32'h0000_0600);
    bus.req_valid = 3'b001;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_ptr = 0;
    bus.req_valid = '0;
    total++; if ({bus.req_ack, bus.req_err, bus.mem_req, bus.busy} !== '0 ||
                 {bus.rsp_data, bus.mem_addr, bus.grant_id} !== '0) begin bad++;
      $display("FAIL reset_mid_outputs: got ack=%b err=%b req=%b busy=%b rsp=%h addr=%h id=%0d want all 0",
               bus.req_ack, bus.req_err, bus.mem_req, bus.busy, bus.rsp_data, bus.mem_addr, bus.grant_id); end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (bus.req_ack !== '0 || bus.mem_req !== 1'b0 || bus.rsp_data !== '0) begin bad++;
        $display("FAIL reset_mid_stray_ack[%0d]: got ack=%b req=%b rsp=%h want 000/0/0", c, bus.req_ack, bus.mem_req, bus.rsp_data); end
    end
    bus.mem_ack = 1'b0;
    // Pointer was 1 before reset; a cleared pointer grants walker 0 first.
    bus.req_valid = 3'b011;
    tick();
    total++; if (bus.grant_id !== 2'd0 || bus.mem_addr !== 32'h0000_0500) begin bad++;
      $display("FAIL reset_mid_pointer: got id=%0d addr=%h want 0/00000500", bus.grant_id, bus.mem_addr); end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [AW-1:0]   m_addr [NREQ];
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] raise;
    logic [DW-1:0]   d;
    int g;
    int lat;
    do_reset();
    pend = '0;
    for (int it = 0; it < 40; it++) begin
      raise = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~pend;
      if ((pend | raise) == '0) raise = NREQ'(1) << $urandom_range(0, NREQ - 1);
      for (int i = 0; i < NREQ; i++)
        if (raise[i]) begin
          m_addr[i] = $urandom;
          set_addr(i, m_addr[i]);
        end
      pend = pend | raise;
      bus.req_valid = pend;
      g = exp_grant(pend, m_ptr);
      tick();
      total++; if (int'(bus.grant_id) != g || bus.mem_req !== 1'b1 || bus.mem_addr !== m_addr[g]) begin bad++;
        $display("FAIL random_grant[%0d]: got id=%0d req=%b addr=%h want %0d/1/%h",
                 it, bus.grant_id, bus.mem_req, bus.mem_addr, g, m_addr[g]); end
      m_ptr = (g + 1) % NREQ;
      // The granted walker may scribble its address or give up; neither
      // affects the access in flight.
      set_addr(g, $urandom);
      if ($urandom_range(0, 3) == 0) bus.req_valid[g] = 1'b0;
      lat = $urandom_range(1, 4);
      for (int c = 1; c < lat; c++) tick();
      d = $urandom;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = d;
      tick();
      bus.mem_ack = 1'b0;
      total++; if (bus.req_ack !== (NREQ'(1) << g) || bus.rsp_data !== d || bus.req_err !== 1'b0) begin bad++;
        $display("FAIL random_ack[%0d]: got ack=%b data=%h err=%b want %b/%h/0",
                 it, bus.req_ack, bus.rsp_data, bus.req_err, NREQ'(1) << g, d); end
      pend[g] = 1'b0;
      bus.req_valid = pend;
      tick();
    end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_addr_hold();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
